// File: rtl/adc_readout_pkg.sv
// rtl/adc_readout_pkg.sv - shared types, widths and output word layout for the ADC readout scheduler
package adc_readout_pkg;

    localparam int NCH     = 4;
    localparam int ADC_W   = 14;
    localparam int IDX_W   = 12;
    localparam int BODY_W  = IDX_W + ADC_W;
    localparam int HDR_LSB = 28;
    localparam int CH_LSB  = 26;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_CAPTURE,
        ST_DRAIN
    } state_t;

    // Output word: {header, channel, index, sample}; body holds {index, sample}.
    function automatic logic [31:0] pack_word(input logic [3:0]        hdr,
                                              input logic [1:0]        ch,
                                              input logic [BODY_W-1:0] body);
        logic [31:0] w;
        w = '0;
        w[HDR_LSB +: 4]  = hdr;
        w[CH_LSB +: 2]   = ch;
        w[0 +: BODY_W]   = body;
        return w;
    endfunction

endpackage

// File: rtl/adc_rr_grant.sv
// rtl/adc_rr_grant.sv - 4-way round-robin grant with pointer that restarts at channel 0 on clear
module adc_rr_grant
    import adc_readout_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clear,
    input  logic           enable,
    input  logic [NCH-1:0] request,
    output logic [NCH-1:0] grant,
    output logic [1:0]     grant_idx
);

    logic [1:0] ptr;
    logic [1:0] idx;
    logic       found;

    always_comb begin
        grant     = '0;
        grant_idx = ptr;
        found     = 1'b0;
        idx       = ptr;
        for (int i = 0; i < NCH; i++) begin
            idx = ptr + 2'(i);
            if (enable && !found && request[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                found      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (clear) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= grant_idx + 2'd1;
        end
    end

endmodule

// File: rtl/adc_readout_sched.sv
// rtl/adc_readout_sched.sv - acquisition FSM, per-channel holding registers and merged output stream
module adc_readout_sched
    import adc_readout_pkg::*;
#(
    parameter logic [3:0] HEADER_ID = 4'b0001,
    parameter int         CNT_W     = 24,
    parameter int         LOST_W    = 8
) (
    input  logic                 BUS_CLK,
    input  logic                 BUS_RST_B,
    input  logic                 START,
    input  logic                 STOP,
    input  logic [NCH-1:0]       CH_EN,
    input  logic [CNT_W-1:0]     SAMPLES,
    input  logic                 TRIG_EN,
    input  logic                 TRIG,
    input  logic [NCH*ADC_W-1:0] CH_DATA,
    input  logic [NCH-1:0]       CH_STB,
    output logic [31:0]          OUT_DATA,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [LOST_W-1:0]    LOST_CNT
);

    state_t             state;
    logic [NCH-1:0]     ch_en_q;
    logic [CNT_W-1:0]   samples_q;
    logic [CNT_W-1:0]   cnt [NCH];
    logic [NCH-1:0]     hold_valid;
    logic [BODY_W-1:0]  hold_data [NCH];
    logic               trig_q;

    logic               start_go;
    logic               out_load;
    logic               all_done;
    logic [NCH-1:0]     ch_done, accept, store, drop, grant;
    logic [1:0]         grant_idx;
    logic [2:0]         drop_count;
    logic [LOST_W:0]    lost_sum;

    assign start_go = (state == ST_IDLE) && START && !STOP;
    assign out_load = !OUT_VALID || OUT_READY;
    assign all_done = &(~ch_en_q | ch_done);

    // A full hold register still accepts a sample if it is being drained this same cycle.
    always_comb begin
        ch_done    = '0;
        accept     = '0;
        store      = '0;
        drop       = '0;
        drop_count = '0;
        for (int n = 0; n < NCH; n++) begin
            ch_done[n] = (samples_q != '0) && (cnt[n] == samples_q);
            accept[n]  = (state == ST_CAPTURE) && ch_en_q[n] && !ch_done[n] && CH_STB[n];
            store[n]   = accept[n] && (!hold_valid[n] || grant[n]);
            drop[n]    = accept[n] && !store[n];
            drop_count = drop_count + {2'b00, drop[n]};
        end
        lost_sum = {1'b0, LOST_CNT} + (LOST_W+1)'(drop_count);
    end

    adc_rr_grant u_grant (
        .clk       (BUS_CLK),
        .rst_n     (BUS_RST_B),
        .clear     (start_go),
        .enable    (out_load),
        .request   (hold_valid),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_ff @(posedge BUS_CLK or negedge BUS_RST_B) begin
        if (!BUS_RST_B) begin
            ch_en_q    <= '0;
            samples_q  <= '0;
            LOST_CNT   <= '0;
            hold_valid <= '0;
            OUT_DATA   <= '0;
            OUT_VALID  <= 1'b0;
            trig_q     <= 1'b0;
            for (int n = 0; n < NCH; n++) begin
                cnt[n]       <= '0;
                hold_data[n] <= '0;
            end
        end else begin
            trig_q <= TRIG;
            if (start_go) begin
                ch_en_q   <= CH_EN;
                samples_q <= SAMPLES;
                LOST_CNT  <= '0;
            end else if (drop_count != '0) begin
                LOST_CNT <= lost_sum[LOST_W] ? '1 : lost_sum[LOST_W-1:0];
            end
            for (int n = 0; n < NCH; n++) begin
                if (start_go) begin
                    cnt[n] <= '0;
                end else if (accept[n]) begin
                    cnt[n] <= cnt[n] + CNT_W'(1);
                end
                if (store[n]) begin
                    hold_valid[n] <= 1'b1;
                    hold_data[n]  <= {cnt[n][IDX_W-1:0], CH_DATA[n*ADC_W +: ADC_W]};
                end else if (grant[n]) begin
                    hold_valid[n] <= 1'b0;
                end
            end
            if (out_load) begin
                OUT_VALID <= |grant;
                if (|grant) begin
                    OUT_DATA <= pack_word(HEADER_ID, grant_idx, hold_data[grant_idx]);
                end
            end
        end
    end

    always_ff @(posedge BUS_CLK or negedge BUS_RST_B) begin
        if (!BUS_RST_B) begin
            state <= ST_IDLE;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_go) begin
                        state <= ST_ARM;
                        BUSY  <= 1'b1;
                    end
                end
                ST_ARM: begin
                    if (STOP) begin
                        state <= ST_DRAIN;
                    end else if (!TRIG_EN || (TRIG && !trig_q)) begin
                        state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (STOP || all_done) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if ((hold_valid == '0) && !OUT_VALID) begin
                        state <= ST_IDLE;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule
